// File: rtl/pmp_check_arbiter.sv
// Shared PMP checker front-end: round-robin arbitration between instruction
// fetch and LSU, driving one combinational checker and returning each verdict
// one cycle later through a per-requester response slot.

// One response slot: EMPTY/FULL state plus the captured verdict.
module pmp_resp_slot #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clr_i,
  input  logic            load_i,
  input  logic            drain_i,
  input  logic            fault_i,
  input  logic [3:0]      cause_i,
  input  logic [XLEN-1:0] tval_i,
  output logic            valid_o,
  output logic            fault_o,
  output logic [3:0]      cause_o,
  output logic [XLEN-1:0] tval_o
);
  typedef enum logic {EMPTY, FULL} slot_e;

  slot_e           state_q, state_d;
  logic            fault_q;
  logic [3:0]      cause_q;
  logic [XLEN-1:0] tval_q;

  // Slot state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= EMPTY;
    else         state_q <= state_d;
  end

  // Next state: clear beats refill, refill beats drain.
  always_comb begin
    state_d = state_q;
    if (clr_i)        state_d = EMPTY;
    else if (load_i)  state_d = FULL;
    else if (drain_i) state_d = EMPTY;
  end

  // Verdict capture on grant; held stable otherwise.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fault_q <= 1'b0;
      cause_q <= '0;
      tval_q  <= '0;
    end else if (load_i) begin
      fault_q <= fault_i;
      cause_q <= cause_i;
      tval_q  <= tval_i;
    end
  end

  // Response fields only read non-zero while a verdict is presented.
  always_comb begin
    valid_o = (state_q == FULL);
    fault_o = valid_o & fault_q;
    cause_o = valid_o ? cause_q : 4'd0;
    tval_o  = valid_o ? tval_q  : '0;
  end
endmodule

module pmp_check_arbiter #(
  parameter int unsigned PLEN = 56,
  parameter int unsigned VLEN = 64,
  parameter int unsigned XLEN = 64
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            if_req_valid_i,
  output logic            if_req_ready_o,
  input  logic [PLEN-1:0] if_paddr_i,
  input  logic [VLEN-1:0] if_vaddr_i,
  input  logic [1:0]      if_priv_i,
  output logic            if_resp_valid_o,
  input  logic            if_resp_ready_i,
  output logic            if_resp_fault_o,
  output logic [XLEN-1:0] if_resp_tval_o,
  input  logic            lsu_req_valid_i,
  output logic            lsu_req_ready_o,
  input  logic [PLEN-1:0] lsu_paddr_i,
  input  logic [VLEN-1:0] lsu_vaddr_i,
  input  logic            lsu_is_store_i,
  input  logic [1:0]      lsu_priv_i,
  output logic            lsu_resp_valid_o,
  input  logic            lsu_resp_ready_i,
  output logic            lsu_resp_fault_o,
  output logic [3:0]      lsu_resp_cause_o,
  output logic [XLEN-1:0] lsu_resp_tval_o,
  output logic [PLEN-1:0] chk_addr_o,
  output logic [1:0]      chk_priv_o,
  output logic [2:0]      chk_access_o,
  input  logic            chk_allow_i
);
  localparam int unsigned NREQ = 2;  // index 0 = fetch, 1 = LSU
  localparam logic [2:0] ACC_READ  = 3'b001;
  localparam logic [2:0] ACC_WRITE = 3'b010;
  localparam logic [2:0] ACC_EXEC  = 3'b100;

  logic [NREQ-1:0]           req_valid, resp_ready, slot_clr;
  logic [NREQ-1:0]           full, drain, can_take, elig, grant;
  logic [NREQ-1:0]           slot_fault;
  logic [NREQ-1:0][3:0]      cause_d, slot_cause;
  logic [NREQ-1:0][XLEN-1:0] vaddr_ext, tval_d, slot_tval;
  logic                      fault_d;
  logic                      last_lsu_q;  // 1: LSU was granted last

  assign req_valid  = {lsu_req_valid_i, if_req_valid_i};
  assign resp_ready = {lsu_resp_ready_i, if_resp_ready_i};
  assign vaddr_ext  = {XLEN'(lsu_vaddr_i), XLEN'(if_vaddr_i)};
  assign slot_clr   = {1'b0, flush_i};

  assign fault_d    = ~chk_allow_i;
  assign cause_d[0] = 4'd1;  // internal only; fetch has no cause port
  assign cause_d[1] = fault_d ? (lsu_is_store_i ? 4'd7 : 4'd5) : 4'd0;

  for (genvar g = 0; g < NREQ; g++) begin : g_req
    assign drain[g]    = full[g] & resp_ready[g];
    assign can_take[g] = ~full[g] | drain[g];
    assign tval_d[g]   = fault_d ? vaddr_ext[g] : '0;

    pmp_resp_slot #(.XLEN(XLEN)) u_slot (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clr_i   (slot_clr[g]),
      .load_i  (grant[g]),
      .drain_i (drain[g]),
      .fault_i (fault_d),
      .cause_i (cause_d[g]),
      .tval_i  (tval_d[g]),
      .valid_o (full[g]),
      .fault_o (slot_fault[g]),
      .cause_o (slot_cause[g]),
      .tval_o  (slot_tval[g])
    );
  end

  assign elig[0] = req_valid[0] & can_take[0] & ~flush_i;
  assign elig[1] = req_valid[1] & can_take[1];

  // Round-robin: on contention the requester not granted last wins.
  assign grant[0] = elig[0] & (~elig[1] | last_lsu_q);
  assign grant[1] = elig[1] & ~grant[0];

  // Last-granted pointer; reset favours fetch on first contention.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     last_lsu_q <= 1'b1;
    else if (|grant) last_lsu_q <= grant[1];
  end

  // Shared checker drive from the winner, idle pattern otherwise.
  always_comb begin
    chk_addr_o   = '0;
    chk_priv_o   = 2'd0;
    chk_access_o = ACC_READ;
    if (grant[0]) begin
      chk_addr_o   = if_paddr_i;
      chk_priv_o   = if_priv_i;
      chk_access_o = ACC_EXEC;
    end else if (grant[1]) begin
      chk_addr_o   = lsu_paddr_i;
      chk_priv_o   = lsu_priv_i;
      chk_access_o = lsu_is_store_i ? ACC_WRITE : ACC_READ;
    end
  end

  assign if_req_ready_o   = grant[0];
  assign lsu_req_ready_o  = grant[1];
  assign if_resp_valid_o  = full[0];
  assign if_resp_fault_o  = slot_fault[0];
  assign if_resp_tval_o   = slot_tval[0];
  assign lsu_resp_valid_o = full[1];
  assign lsu_resp_fault_o = slot_fault[1];
  assign lsu_resp_cause_o = slot_cause[1];
  assign lsu_resp_tval_o  = slot_tval[1];
endmodule

// File: tb/tb_pmp_check_arbiter.sv
// Directed and randomized bench for pmp_check_arbiter with a behavioural
// transaction model and a small checker model driving chk_allow_i.
module tb_pmp_check_arbiter;
  localparam int PLEN = 56, VLEN = 64, XLEN = 64;

  logic            clk_i = 1'b0, rst_ni = 1'b0, flush_i = 1'b0;
  logic            if_req_valid_i = 1'b0, if_req_ready_o;
  logic [PLEN-1:0] if_paddr_i = '0;
  logic [VLEN-1:0] if_vaddr_i = '0;
  logic [1:0]      if_priv_i = '0;
  logic            if_resp_valid_o, if_resp_ready_i = 1'b0, if_resp_fault_o;
  logic [XLEN-1:0] if_resp_tval_o;
  logic            lsu_req_valid_i = 1'b0, lsu_req_ready_o;
  logic [PLEN-1:0] lsu_paddr_i = '0;
  logic [VLEN-1:0] lsu_vaddr_i = '0;
  logic            lsu_is_store_i = 1'b0;
  logic [1:0]      lsu_priv_i = '0;
  logic            lsu_resp_valid_o, lsu_resp_ready_i = 1'b0, lsu_resp_fault_o;
  logic [3:0]      lsu_resp_cause_o;
  logic [XLEN-1:0] lsu_resp_tval_o;
  logic [PLEN-1:0] chk_addr_o;
  logic [1:0]      chk_priv_o;
  logic [2:0]      chk_access_o;
  logic            chk_allow_i;

  int checks = 0, errors = 0;
  int allow_mode = 0;  // 0 allow all, 1 deny all, 2 rule-based

  pmp_check_arbiter #(.PLEN(PLEN), .VLEN(VLEN), .XLEN(XLEN)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .if_req_valid_i(if_req_valid_i), .if_req_ready_o(if_req_ready_o),
    .if_paddr_i(if_paddr_i), .if_vaddr_i(if_vaddr_i), .if_priv_i(if_priv_i),
    .if_resp_valid_o(if_resp_valid_o), .if_resp_ready_i(if_resp_ready_i),
    .if_resp_fault_o(if_resp_fault_o), .if_resp_tval_o(if_resp_tval_o),
    .lsu_req_valid_i(lsu_req_valid_i), .lsu_req_ready_o(lsu_req_ready_o),
    .lsu_paddr_i(lsu_paddr_i), .lsu_vaddr_i(lsu_vaddr_i),
    .lsu_is_store_i(lsu_is_store_i), .lsu_priv_i(lsu_priv_i),
    .lsu_resp_valid_o(lsu_resp_valid_o), .lsu_resp_ready_i(lsu_resp_ready_i),
    .lsu_resp_fault_o(lsu_resp_fault_o), .lsu_resp_cause_o(lsu_resp_cause_o),
    .lsu_resp_tval_o(lsu_resp_tval_o),
    .chk_addr_o(chk_addr_o), .chk_priv_o(chk_priv_o),
    .chk_access_o(chk_access_o), .chk_allow_i(chk_allow_i)
  );

  always #5 clk_i = ~clk_i;

  // Toy PMP rule: M-mode always allowed; otherwise addr bit 12 must be clear
  // and writes to regions with bit 13 set are refused.
  function automatic logic rule_allow(logic [PLEN-1:0] a, logic [1:0] p, logic [2:0] acc);
    return (p == 2'd3) || ((a[12] == 1'b0) && !(acc[1] && a[13]));
  endfunction

  always_comb begin
    case (allow_mode)
      0:       chk_allow_i = 1'b1;
      1:       chk_allow_i = 1'b0;
      default: chk_allow_i = rule_allow(chk_addr_o, chk_priv_o, chk_access_o);
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  // Reference model state for the random phase.
  bit              m_full[2], m_fault[2];
  logic [3:0]      m_cause;
  logic [XLEN-1:0] m_tval[2];
  int              m_last;  // 0 = fetch granted last, 1 = LSU

  initial begin
    // Reset state
    #12;
    check("rst_if_valid", 64'(if_resp_valid_o), 64'd0);
    check("rst_lsu_valid", 64'(lsu_resp_valid_o), 64'd0);
    check("rst_if_fault", 64'(if_resp_fault_o), 64'd0);
    check("rst_lsu_cause", 64'(lsu_resp_cause_o), 64'd0);
    check("rst_lsu_tval", lsu_resp_tval_o, 64'd0);
    check("rst_chk_access", 64'(chk_access_o), 64'd1);
    @(negedge clk_i); rst_ni = 1'b1;
    step();

    // Fetch, allowed
    if_req_valid_i = 1; if_paddr_i = 56'h8000_0000; if_vaddr_i = 64'h8000_0000;
    if_priv_i = 2'd3; if_resp_ready_i = 1; lsu_resp_ready_i = 1; allow_mode = 0;
    #1;
    check("t1_if_ready", 64'(if_req_ready_o), 64'd1);
    check("t1_chk_access", 64'(chk_access_o), 64'd4);
    check("t1_chk_addr", 64'(chk_addr_o), 64'h8000_0000);
    check("t1_chk_priv", 64'(chk_priv_o), 64'd3);
    step(); if_req_valid_i = 0;
    check("t1_if_valid", 64'(if_resp_valid_o), 64'd1);
    check("t1_if_fault", 64'(if_resp_fault_o), 64'd0);
    check("t1_if_tval", if_resp_tval_o, 64'd0);

    // LSU store denied, then load denied
    lsu_req_valid_i = 1; lsu_is_store_i = 1; lsu_vaddr_i = 64'h1234;
    lsu_paddr_i = 56'h1234; lsu_priv_i = 2'd0; allow_mode = 1;
    #1;
    check("t2_lsu_ready", 64'(lsu_req_ready_o), 64'd1);
    check("t2_chk_access", 64'(chk_access_o), 64'd2);
    step();
    check("t2_if_drained", 64'(if_resp_valid_o), 64'd0);
    check("t2_lsu_valid", 64'(lsu_resp_valid_o), 64'd1);
    check("t2_lsu_fault", 64'(lsu_resp_fault_o), 64'd1);
    check("t2_lsu_cause", 64'(lsu_resp_cause_o), 64'd7);
    check("t2_lsu_tval", lsu_resp_tval_o, 64'h1234);
    lsu_is_store_i = 0; lsu_vaddr_i = 64'h1238;
    #1;
    check("t2_ld_ready", 64'(lsu_req_ready_o), 64'd1);
    check("t2_ld_access", 64'(chk_access_o), 64'd1);
    step(); lsu_req_valid_i = 0;
    check("t2_ld_cause", 64'(lsu_resp_cause_o), 64'd5);
    check("t2_ld_tval", lsu_resp_tval_o, 64'h1238);

    // Continuous contention alternates starting with fetch
    allow_mode = 0; if_req_valid_i = 1; lsu_req_valid_i = 1;
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("t3_if_ready%0d", i), 64'(if_req_ready_o), 64'((i % 2) == 0));
      check($sformatf("t3_lsu_ready%0d", i), 64'(lsu_req_ready_o), 64'((i % 2) == 1));
      step();
    end
    if_req_valid_i = 0; lsu_req_valid_i = 0;
    step();

    // LSU backpressure while fetch streams
    lsu_req_valid_i = 1; lsu_is_store_i = 1; lsu_vaddr_i = 64'h5550;
    lsu_resp_ready_i = 0; allow_mode = 1;
    #1;
    check("t4_lsu_grant", 64'(lsu_req_ready_o), 64'd1);
    step();
    if_req_valid_i = 1; allow_mode = 0; lsu_vaddr_i = 64'h9999;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("t4_lsu_ready%0d", i), 64'(lsu_req_ready_o), 64'd0);
      check($sformatf("t4_if_ready%0d", i), 64'(if_req_ready_o), 64'd1);
      check($sformatf("t4_lsu_valid%0d", i), 64'(lsu_resp_valid_o), 64'd1);
      check($sformatf("t4_lsu_cause%0d", i), 64'(lsu_resp_cause_o), 64'd7);
      check($sformatf("t4_lsu_tval%0d", i), lsu_resp_tval_o, 64'h5550);
      step();
    end
    if_req_valid_i = 0; lsu_req_valid_i = 0; lsu_resp_ready_i = 1;
    step();

    // Flush of a faulting fetch verdict
    if_req_valid_i = 1; if_vaddr_i = 64'hABC0; allow_mode = 1; if_resp_ready_i = 0;
    #1;
    check("t5_if_grant", 64'(if_req_ready_o), 64'd1);
    step();
    check("t5_if_fault", 64'(if_resp_fault_o), 64'd1);
    check("t5_if_tval", if_resp_tval_o, 64'hABC0);
    flush_i = 1; if_resp_ready_i = 1;
    #1;
    check("t5_flush_noready", 64'(if_req_ready_o), 64'd0);
    check("t5_flush_chk_idle", 64'(chk_access_o), 64'd1);
    step(); flush_i = 0; if_resp_ready_i = 0;
    check("t5_flushed_valid", 64'(if_resp_valid_o), 64'd0);
    #1;
    check("t5_after_grant", 64'(if_req_ready_o), 64'd1);
    step(); if_req_valid_i = 0;
    check("t5_after_valid", 64'(if_resp_valid_o), 64'd1);

    // Reset while both slots are full
    lsu_req_valid_i = 1; lsu_resp_ready_i = 0;
    step();  // fetch slot blocked; LSU granted
    lsu_req_valid_i = 0;
    check("t6_if_full", 64'(if_resp_valid_o), 64'd1);
    check("t6_lsu_full", 64'(lsu_resp_valid_o), 64'd1);
    rst_ni = 0; #1;
    check("t6_rst_if_valid", 64'(if_resp_valid_o), 64'd0);
    check("t6_rst_lsu_valid", 64'(lsu_resp_valid_o), 64'd0);
    #6; rst_ni = 1;
    step();
    check("t6_post_if_valid", 64'(if_resp_valid_o), 64'd0);
    if_req_valid_i = 1; lsu_req_valid_i = 1; if_resp_ready_i = 1; lsu_resp_ready_i = 1;
    #1;
    check("t6_first_if", 64'(if_req_ready_o), 64'd1);
    check("t6_first_lsu", 64'(lsu_req_ready_o), 64'd0);
    if_req_valid_i = 0; lsu_req_valid_i = 0;

    // Randomized phase against the transaction model
    rst_ni = 0; #3; rst_ni = 1;
    m_full = '{0, 0}; m_fault = '{0, 0}; m_last = 1; allow_mode = 2;
    step();
    for (int c = 0; c < 400; c++) begin
      bit rv[2], dr[2], el[2], g[2];
      bit alw, flush;
      logic [PLEN-1:0] ea; logic [1:0] ep; logic [2:0] eacc;
      if_req_valid_i   = ($urandom_range(0, 3) != 0);
      lsu_req_valid_i  = ($urandom_range(0, 3) != 0);
      if_resp_ready_i  = ($urandom_range(0, 3) != 0);
      lsu_resp_ready_i = ($urandom_range(0, 3) != 0);
      flush_i          = ($urandom_range(0, 9) == 0);
      if_paddr_i  = PLEN'({$urandom(), $urandom()});
      lsu_paddr_i = PLEN'({$urandom(), $urandom()});
      if_vaddr_i  = {$urandom(), $urandom()};
      lsu_vaddr_i = {$urandom(), $urandom()};
      if_priv_i   = 2'($urandom_range(0, 3));
      lsu_priv_i  = 2'($urandom_range(0, 3));
      lsu_is_store_i = $urandom_range(0, 1) != 0;
      #1;
      flush = flush_i;
      rv[0] = if_req_valid_i; rv[1] = lsu_req_valid_i;
      dr[0] = m_full[0] && if_resp_ready_i; dr[1] = m_full[1] && lsu_resp_ready_i;
      el[0] = rv[0] && (!m_full[0] || dr[0]) && !flush;
      el[1] = rv[1] && (!m_full[1] || dr[1]);
      if (el[0] && el[1]) begin g[0] = (m_last == 1); g[1] = (m_last == 0); end
      else begin g[0] = el[0]; g[1] = el[1]; end
      ea = '0; ep = 2'd0; eacc = 3'b001;
      if (g[0]) begin ea = if_paddr_i; ep = if_priv_i; eacc = 3'b100; end
      if (g[1]) begin ea = lsu_paddr_i; ep = lsu_priv_i; eacc = lsu_is_store_i ? 3'b010 : 3'b001; end
      alw = rule_allow(ea, ep, eacc);

      check("r_if_ready", 64'(if_req_ready_o), 64'(g[0]));
      check("r_lsu_ready", 64'(lsu_req_ready_o), 64'(g[1]));
      check("r_chk_addr", 64'(chk_addr_o), 64'(ea));
      check("r_chk_priv", 64'(chk_priv_o), 64'(ep));
      check("r_chk_access", 64'(chk_access_o), 64'(eacc));
      check("r_if_valid", 64'(if_resp_valid_o), 64'(m_full[0]));
      check("r_lsu_valid", 64'(lsu_resp_valid_o), 64'(m_full[1]));
      if (m_full[0]) begin
        check("r_if_fault", 64'(if_resp_fault_o), 64'(m_fault[0]));
        check("r_if_tval", if_resp_tval_o, m_tval[0]);
      end
      if (m_full[1]) begin
        check("r_lsu_fault", 64'(lsu_resp_fault_o), 64'(m_fault[1]));
        check("r_lsu_cause", 64'(lsu_resp_cause_o), 64'(m_cause));
        check("r_lsu_tval", lsu_resp_tval_o, m_tval[1]);
      end

      // Advance the model across the clock edge
      if (flush) m_full[0] = 0;
      else if (g[0]) begin
        m_full[0] = 1; m_fault[0] = !alw; m_tval[0] = alw ? 64'd0 : if_vaddr_i;
      end else if (dr[0]) m_full[0] = 0;
      if (g[1]) begin
        m_full[1] = 1; m_fault[1] = !alw; m_tval[1] = alw ? 64'd0 : lsu_vaddr_i;
        m_cause = alw ? 4'd0 : (lsu_is_store_i ? 4'd7 : 4'd5);
      end else if (dr[1]) m_full[1] = 0;
      if (g[0]) m_last = 0;
      if (g[1]) m_last = 1;
      @(posedge clk_i); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
